// File: rtl/lebug_pkg.sv
// Shared types and constants for the lebug datapath blocks.
package lebug_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_FRAME   = 2'd1,
    MODE_RUNNING = 2'd2
  } mode_e;

  localparam int EOF_FRAME_BIT = 0;
  localparam int BOF_FRAME_BIT = 0;

endpackage

// File: rtl/sat_vector_adder.sv
// Combinational N-lane unsigned saturating adder; any_sat flags a clamped lane.
module sat_vector_adder #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic [N*DATA_WIDTH-1:0] a,
  input  logic [N*DATA_WIDTH-1:0] b,
  output logic [N*DATA_WIDTH-1:0] sum,
  output logic                    any_sat
);

  function automatic logic [DATA_WIDTH-1:0] sat_lane(input logic [DATA_WIDTH:0] wide);
    return wide[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : wide[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH:0] wide [N];
  logic [N-1:0]        carry;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign wide[i] = {1'b0, a[i*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, b[i*DATA_WIDTH +: DATA_WIDTH]};
    assign carry[i] = wide[i][DATA_WIDTH];
    assign sum[i*DATA_WIDTH +: DATA_WIDTH] = sat_lane(wide[i]);
  end

  assign any_sat = |carry;

endmodule

// File: rtl/chain_accumulator_unit.sv
// Per-chain frame/running accumulator of N-lane count vectors with a 1-cycle
// registered output and byte-serial per-chain mode configuration.
module chain_accumulator_unit
  import lebug_pkg::*;
#(
  parameter int                         N                  = 8,
  parameter int                         DATA_WIDTH         = 32,
  parameter int                         MAX_CHAINS         = 4,
  parameter logic [7:0]                 PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_MODE       = '0,
  localparam int                        CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tracing,
  input  logic                    valid_in,
  input  logic [1:0]              eof_in,
  input  logic [1:0]              bof_in,
  input  logic [CW-1:0]           chainId_in,
  input  logic [7:0]              configId,
  input  logic [7:0]              configData,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic [CW-1:0]           chainId_out,
  output logic                    valid_out,
  output logic [1:0]              eof_out,
  output logic [1:0]              bof_out,
  output logic                    overflow_out
);

  logic [N*DATA_WIDTH-1:0] acc [MAX_CHAINS];
  logic [MAX_CHAINS-1:0]   ovf;
  logic [7:0]              mode [MAX_CHAINS];
  logic [7:0]              cfg_cnt;

  logic [N*DATA_WIDTH-1:0] vector_p1;
  logic [CW-1:0]           chain_p1;
  logic                    vld_p1;
  logic [1:0]              eof_p1;
  logic [1:0]              bof_p1;
  logic                    ovf_p1;

  logic [1:0]              msel;
  logic                    accumulate;
  logic                    bof_p0;
  logic                    eof_p0;
  logic                    take_p0;
  logic                    emit_p0;
  logic                    ovf_sum_p0;
  logic                    any_sat_p0;
  logic [N*DATA_WIDTH-1:0] base_p0;
  logic [N*DATA_WIDTH-1:0] sum_p0;

  // Stage p0: mode decode, base select and saturating add
  assign msel       = mode[chainId_in][1:0];
  assign accumulate = (msel == MODE_FRAME) || (msel == MODE_RUNNING);
  assign bof_p0     = bof_in[BOF_FRAME_BIT];
  assign eof_p0     = eof_in[EOF_FRAME_BIT];
  assign take_p0    = tracing && valid_in;
  assign base_p0    = bof_p0 ? '0 : acc[chainId_in];
  assign emit_p0    = accumulate ? ((msel == MODE_RUNNING) || eof_p0) : 1'b1;
  assign ovf_sum_p0 = (!bof_p0 && ovf[chainId_in]) || any_sat_p0;

  sat_vector_adder #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .a       (base_p0),
    .b       (vector_in),
    .sum     (sum_p0),
    .any_sat (any_sat_p0)
  );

  // Stage p1: registered result and per-chain state update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1    <= 1'b0;
      vector_p1 <= '0;
      chain_p1  <= '0;
      eof_p1    <= '0;
      bof_p1    <= '0;
      ovf_p1    <= 1'b0;
      ovf       <= '0;
      cfg_cnt   <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        acc[c]  <= '0;
        mode[c] <= INITIAL_MODE[c];
      end
    end else if (tracing) begin
      vld_p1 <= take_p0 && emit_p0;
      if (take_p0 && emit_p0) begin
        vector_p1 <= accumulate ? sum_p0 : vector_in;
        chain_p1  <= chainId_in;
        eof_p1    <= eof_in;
        bof_p1    <= bof_in;
        ovf_p1    <= accumulate && ovf_sum_p0;
      end
      // An eof closes the frame: the sum leaves on the output, the chain restarts from 0
      if (take_p0 && accumulate) begin
        acc[chainId_in] <= eof_p0 ? '0 : sum_p0;
        ovf[chainId_in] <= eof_p0 ? 1'b0 : ovf_sum_p0;
      end
    end else begin
      vld_p1 <= 1'b0;
      if (configId == PERSONAL_CONFIG_ID) begin
        if (cfg_cnt < 8'(MAX_CHAINS)) mode[cfg_cnt[CW-1:0]] <= configData;
        if (cfg_cnt != 8'hFF) cfg_cnt <= cfg_cnt + 8'd1;
      end else begin
        cfg_cnt <= '0;
      end
    end
  end

  assign vector_out   = vector_p1;
  assign chainId_out  = chain_p1;
  assign valid_out    = vld_p1;
  assign eof_out      = eof_p1;
  assign bof_out      = bof_p1;
  assign overflow_out = ovf_p1;

endmodule

// File: tb/tb_chain_accumulator_unit.sv
// Scoreboard bench for chain_accumulator_unit: a behavioural model queues the
// expected emissions as vectors are driven; each output cycle is compared.
module tb_chain_accumulator_unit;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int MC = 4;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              tracing;
  logic              valid_in;
  logic [1:0]        eof_in;
  logic [1:0]        bof_in;
  logic [CW-1:0]     chainId_in;
  logic [7:0]        configId;
  logic [7:0]        configData;
  logic [N*DW-1:0]   vector_in;
  logic [N*DW-1:0]   vector_out;
  logic [CW-1:0]     chainId_out;
  logic              valid_out;
  logic [1:0]        eof_out;
  logic [1:0]        bof_out;
  logic              overflow_out;

  chain_accumulator_unit #(
    .N                  (N),
    .DATA_WIDTH         (DW),
    .MAX_CHAINS         (MC),
    .PERSONAL_CONFIG_ID (8'd0),
    .INITIAL_MODE       ('0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tracing      (tracing),
    .valid_in     (valid_in),
    .eof_in       (eof_in),
    .bof_in       (bof_in),
    .chainId_in   (chainId_in),
    .configId     (configId),
    .configData   (configData),
    .vector_in    (vector_in),
    .vector_out   (vector_out),
    .chainId_out  (chainId_out),
    .valid_out    (valid_out),
    .eof_out      (eof_out),
    .bof_out      (bof_out),
    .overflow_out (overflow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*DW-1:0] vec;
    logic [CW-1:0]   chain;
    logic [1:0]      eof;
    logic [1:0]      bof;
    logic            ovf;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] macc [MC][N];
  bit            movf [MC];
  logic [7:0]    mmode [MC];
  int            mcnt;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] val);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = val;
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < MC; c++) begin
      for (int i = 0; i < N; i++) macc[c][i] = '0;
      movf[c]  = 1'b0;
      mmode[c] = 8'd0;
    end
    mcnt = 0;
    expq.delete();
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    if (expq.size() > 0) begin
      x = expq.pop_front();
      check({tag, ".valid"}, N*DW'(valid_out), N*DW'(1));
      check({tag, ".vec"}, vector_out, x.vec);
      check({tag, ".chain"}, N*DW'(chainId_out), N*DW'(x.chain));
      check({tag, ".eof"}, N*DW'(eof_out), N*DW'(x.eof));
      check({tag, ".bof"}, N*DW'(bof_out), N*DW'(x.bof));
      check({tag, ".ovf"}, N*DW'(overflow_out), N*DW'(x.ovf));
    end else begin
      check({tag, ".idle"}, N*DW'(valid_out), '0);
    end
  endtask

  task automatic send(input string tag, input int ch, input logic [1:0] b, input logic [1:0] e,
                      input logic [N*DW-1:0] v);
    exp_t            x;
    logic [1:0]      m;
    logic [DW:0]     w;
    logic [DW-1:0]   base;
    logic [N*DW-1:0] s;
    bit              ov;
    bit              emit;
    tracing    = 1'b1;
    valid_in   = 1'b1;
    chainId_in = CW'(ch);
    bof_in     = b;
    eof_in     = e;
    vector_in  = v;
    configId   = 8'hFF;
    m = mmode[ch][1:0];
    if (m == 2'd1 || m == 2'd2) begin
      ov = b[0] ? 1'b0 : movf[ch];
      for (int i = 0; i < N; i++) begin
        base = b[0] ? '0 : macc[ch][i];
        w = {1'b0, base} + {1'b0, v[i*DW +: DW]};
        if (w[DW]) begin
          s[i*DW +: DW] = '1;
          ov = 1'b1;
        end else begin
          s[i*DW +: DW] = w[DW-1:0];
        end
      end
      emit = (m == 2'd2) || e[0];
      for (int i = 0; i < N; i++) macc[ch][i] = e[0] ? '0 : s[i*DW +: DW];
      movf[ch] = e[0] ? 1'b0 : ov;
    end else begin
      s    = v;
      ov   = 1'b0;
      emit = 1'b1;
    end
    if (emit) begin
      x.vec = s; x.chain = CW'(ch); x.eof = e; x.bof = b; x.ovf = ov;
      expq.push_back(x);
    end
    @(posedge clk); #1;
    check_out(tag);
  endtask

  task automatic cfg(input logic [7:0] id, input logic [7:0] data);
    tracing    = 1'b0;
    valid_in   = 1'b1;
    vector_in  = fill(32'hDEAD);
    configId   = id;
    configData = data;
    if (id == 8'd0) begin
      if (mcnt < MC) mmode[mcnt] = data;
      if (mcnt < 255) mcnt++;
    end else begin
      mcnt = 0;
    end
    @(posedge clk); #1;
    check_out("cfg");
  endtask

  task automatic idle();
    tracing  = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    check_out("idle");
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    tracing  = 1'b1;
    valid_in = 1'b1;
    @(posedge clk); #1;
    model_clear();
    check("rst.valid", N*DW'(valid_out), '0);
    check("rst.vec", vector_out, '0);
    check("rst.chain", N*DW'(chainId_out), '0);
    check("rst.eof", N*DW'(eof_out), '0);
    check("rst.bof", N*DW'(bof_out), '0);
    check("rst.ovf", N*DW'(overflow_out), '0);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [N*DW-1:0] v;
    reset_n = 1'b0; tracing = 1'b1; valid_in = 1'b0; eof_in = '0; bof_in = '0;
    chainId_in = '0; configId = 8'hFF; configData = '0; vector_in = '0;
    model_clear();
    do_reset();

    // Modes {2,0,1,2}; the fifth byte lands past the last chain
    cfg(8'd0, 8'd2); cfg(8'd0, 8'd0); cfg(8'd0, 8'd1); cfg(8'd0, 8'd2); cfg(8'd0, 8'd9);

    // Reset mid-frame on the FRAME chain, then a bof+eof vector after reconfiguring
    send("pre_rst", 2, 2'b01, 2'b00, fill(32'd3));
    do_reset();
    cfg(8'd0, 8'd2); cfg(8'd0, 8'd0); cfg(8'd0, 8'd1); cfg(8'd0, 8'd2);
    send("boe5", 2, 2'b01, 2'b01, fill(32'd5));

    // PASS on chain 1
    send("pass", 1, 2'b10, 2'b10, fill(32'd77));

    // RUNNING on chain 0: 10, 30, 60, then a fresh start
    send("run10", 0, 2'b01, 2'b00, fill(32'd10));
    send("run20", 0, 2'b00, 2'b00, fill(32'd20));
    send("run30", 0, 2'b00, 2'b01, fill(32'd30));
    send("run7", 0, 2'b00, 2'b00, fill(32'd7));

    // Counter restart: new id, then modes {1,1,1,2}
    cfg(8'd3, 8'd0);
    cfg(8'd0, 8'd1); cfg(8'd0, 8'd1); cfg(8'd0, 8'd1); cfg(8'd0, 8'd2);

    // FRAME chain 1: 1+2+3
    send("fr1", 1, 2'b01, 2'b00, fill(32'd1));
    send("fr2", 1, 2'b00, 2'b00, fill(32'd2));
    send("fr3", 1, 2'b00, 2'b01, fill(32'd3));

    // Interleaved chains 0 and 2
    for (int k = 0; k < 4; k++) begin
      send("il0", 0, {1'b0, k == 0}, {1'b0, k == 3}, fill(32'd1));
      send("il2", 2, {1'b0, k == 0}, {1'b0, k == 3}, fill(32'd100));
    end

    // Saturation on lane 0 only
    v = fill(32'd1); v[DW-1:0] = 32'hFFFF_FFF0;
    send("sat_a", 1, 2'b01, 2'b00, v);
    v = fill(32'd2); v[DW-1:0] = 32'h20;
    send("sat_b", 1, 2'b00, 2'b01, v);
    send("nsat_a", 1, 2'b01, 2'b00, fill(32'd4));
    send("nsat_b", 1, 2'b00, 2'b01, fill(32'd4));

    // Sum held across a tracing pause
    send("hold_a", 2, 2'b01, 2'b00, fill(32'd5));
    cfg(8'h55, 8'd0); cfg(8'h55, 8'd0);
    idle();
    send("hold_b", 2, 2'b00, 2'b01, fill(32'd5));

    // Random traffic across all chains, including near-saturation values
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < N; i++)
        v[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                                   : 32'($urandom_range(0, 1000));
      send("rnd", $urandom_range(0, MC - 1), 2'($urandom_range(0, 3)) & {1'b1, $urandom_range(0, 3) == 0},
           2'($urandom_range(0, 3)) & {1'b1, $urandom_range(0, 3) == 0}, v);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
